sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param.sv | 106 ++++++++++
 tb/tb_sync_fifo_param.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock parameterised FIFO with registered flags and optional FWFT read port
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 256,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             wen,
    input  logic             ren,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_W    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_W    = (AW+1)'(AE_LEVEL);
    localparam logic [AW:0] ONE_W   = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [AW:0]      cnt_nxt;
    logic             wr_ok;
    logic             rd_ok;

    // Acceptance looks only at the registered flags, so a full FIFO can never
    // take a write even if a read frees a slot on the same edge.
    assign wr_ok = wen & ~full;
    assign rd_ok = ren & ~empty;

    always_comb begin
        cnt_nxt = count;
        if (wr_ok && !rd_ok) begin
            cnt_nxt = count + ONE_W;
        end else if (rd_ok && !wr_ok) begin
            cnt_nxt = count - ONE_W;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + ONE_W;
            end
            if (rd_ok) begin
                rptr <= rptr + ONE_W;
            end
            count        <= cnt_nxt;
            full         <= (cnt_nxt == DEPTH_W);
            empty        <= (cnt_nxt == '0);
            almost_full  <= (cnt_nxt >= AF_W);
            almost_empty <= (cnt_nxt <= AE_W);
            overflow     <= (overflow  & ~clr_err) | (wen & full);
            underflow    <= (underflow & ~clr_err) | (ren & empty);
        end
    end

    // Storage is deliberately left out of reset; stale words are unreachable
    // because the pointers restart together.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout = empty ? '0 : mem[rptr[AW-1:0]];
        end else begin : g_std
            logic [WIDTH-1:0] dout_q;

            always_ff @(posedge clk or negedge rst_) begin
                if (!rst_) begin
                    dout_q <= '0;
                end else if (rd_ok) begin
                    dout_q <= mem[rptr[AW-1:0]];
                end
            end

            assign dout = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench for sync_fifo_param (standard and FWFT instances)
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wen, ren, clr_err;
    logic [7:0] din, dout;
    logic       full, empty, af, ae, ovf, unf;
    logic [3:0] count;

    logic       wen1, ren1, clr_err1;
    logic [7:0] din1, dout1;
    logic       full1, empty1, af1, ae1, ovf1, unf1;
    logic [3:0] count1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_std (
        .clk(clk), .rst_(rst_n), .wen(wen), .ren(ren), .clr_err(clr_err), .din(din),
        .dout(dout), .full(full), .empty(empty), .almost_full(af), .almost_empty(ae),
        .count(count), .overflow(ovf), .underflow(unf)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst_(rst_n), .wen(wen1), .ren(ren1), .clr_err(clr_err1), .din(din1),
        .dout(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .count(count1), .overflow(ovf1), .underflow(unf1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"},  32'(full),  32'd0);
        check({tag, "_af"},    32'(af),    32'd0);
        check({tag, "_ae"},    32'(ae),    32'd1);
        check({tag, "_ovf"},   32'(ovf),   32'd0);
        check({tag, "_unf"},   32'(unf),   32'd0);
        check({tag, "_dout"},  32'(dout),  32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        wen = 0; ren = 0; clr_err = 0; din = '0;
        wen1 = 0; ren1 = 0; clr_err1 = 0; din1 = '0;
        tick();
        tick();
        check_reset_state("rst");
        check("rst_fwft_empty", 32'(empty1), 32'd1);
        rst_n = 1'b1;
        tick();

        // Fill 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            wen = 1; din = 8'(i);
            tick();
            check($sformatf("fill_count_%0d", i), 32'(count), 32'(i));
            check($sformatf("fill_ae_%0d", i),    32'(ae),    32'(i <= 2));
            check($sformatf("fill_af_%0d", i),    32'(af),    32'(i >= 6));
            check($sformatf("fill_full_%0d", i),  32'(full),  32'(i == 8));
        end
        wen = 0;

        // Overflow while full, then clear
        wen = 1; din = 8'hFF;
        tick();
        wen = 0;
        check("ovf_set", 32'(ovf), 32'd1);
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_full", 32'(full), 32'd1);
        clr_err = 1;
        tick();
        clr_err = 0;
        check("ovf_clr", 32'(ovf), 32'd0);

        // Drain; contents must be untouched by the rejected 0xFF
        for (int i = 1; i <= 8; i++) begin
            ren = 1;
            tick();
            check($sformatf("drain_dout_%0d", i),  32'(dout),  32'(i));
            check($sformatf("drain_count_%0d", i), 32'(count), 32'(8 - i));
        end
        check("drain_empty", 32'(empty), 32'd1);
        tick();
        ren = 0;
        check("unf_set", 32'(unf), 32'd1);
        check("unf_dout_hold", 32'(dout), 32'h08);
        check("unf_count", 32'(count), 32'd0);
        clr_err = 1;
        tick();
        clr_err = 0;
        check("unf_clr", 32'(unf), 32'd0);

        // Preload 4 words, then 20 simultaneous read/write cycles across wrap
        for (int i = 0; i < 4; i++) begin
            wen = 1; din = 8'(8'h10 + i);
            tick();
        end
        for (int k = 0; k < 20; k++) begin
            wen = 1; ren = 1; din = 8'(8'h14 + k);
            tick();
            check($sformatf("wrap_count_%0d", k), 32'(count), 32'd4);
            check($sformatf("wrap_dout_%0d", k),  32'(dout),  32'(8'h10 + k));
        end
        wen = 0; ren = 0;

        // Top up to full (holds 0x24..0x2B), then wen+ren while full
        for (int i = 0; i < 4; i++) begin
            wen = 1; din = 8'(8'h28 + i);
            tick();
        end
        check("topup_full", 32'(full), 32'd1);
        wen = 1; ren = 1; din = 8'hEE;
        tick();
        wen = 0; ren = 0;
        check("fullrw_count", 32'(count), 32'd7);
        check("fullrw_ovf", 32'(ovf), 32'd1);
        check("fullrw_dout", 32'(dout), 32'h24);
        check("fullrw_full", 32'(full), 32'd0);
        clr_err = 1;
        tick();
        clr_err = 0;

        // FWFT instance: word visible the same cycle empty falls
        wen1 = 1; din1 = 8'hA5;
        tick();
        wen1 = 0;
        check("fwft_empty", 32'(empty1), 32'd0);
        check("fwft_dout", 32'(dout1), 32'hA5);
        check("fwft_count", 32'(count1), 32'd1);
        ren1 = 1;
        tick();
        ren1 = 0;
        check("fwft_pop_empty", 32'(empty1), 32'd1);

        // Two reads bring count to 5, then async reset between edges
        ren = 1;
        tick();
        check("pre_rst_dout_a", 32'(dout), 32'h25);
        tick();
        ren = 0;
        check("pre_rst_dout_b", 32'(dout), 32'h26);
        check("pre_rst_count", 32'(count), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async");
        tick();
        rst_n = 1'b1;
        tick();

        // From empty: simultaneous wen/ren takes the write, flags underflow
        wen = 1; ren = 1; din = 8'h3C;
        tick();
        wen = 0; ren = 0;
        check("post_rst_count", 32'(count), 32'd1);
        check("post_rst_unf", 32'(unf), 32'd1);
        ren = 1;
        tick();
        ren = 0;
        check("post_rst_dout", 32'(dout), 32'h3C);
        check("post_rst_empty", 32'(empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
